spi_slave: RTL and testbench

SPI mode-0 slave, the far end of spi_master: MSB first, 8-bit frames, cs active-low. sclk/cs/mosi are asynchronous to clk; they are synchronised and edge-detected internally, so the block is single-clock. Each received byte is presented with a one-cycle valid strobe. Each transmitted byte comes from a one-entry holding register loaded by the local host.

---
 rtl/spi_slave_if.sv | 27 ++
 rtl/spi_slave.sv | 208 ++++++++++++++++++++
 tb/tb_spi_slave.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// Bus bundle for spi_slave: the SPI pins plus the local host byte interface.
// The slave modport is the DUT view; the master modport is the driving side.
interface spi_slave_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  cs;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;
  logic [DATA_WIDTH-1:0] data_send_slave;
  logic                  data_send_enable;
  logic [DATA_WIDTH-1:0] data_receive_slave;
  logic                  data_receive_slave_enable;
  logic                  tx_underrun;
  logic                  frame_abort;
  logic                  busy;

  modport slave (
    input  cs, sclk, mosi, data_send_slave, data_send_enable,
    output miso, data_receive_slave, data_receive_slave_enable, tx_underrun, frame_abort, busy
  );

  modport master (
    output cs, sclk, mosi, data_send_slave, data_send_enable,
    input  miso, data_receive_slave, data_receive_slave_enable, tx_underrun, frame_abort, busy
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first. cs/sclk/mosi are synchronised into clk and edge-detected;
// received bytes are strobed out, transmitted bytes come from a one-entry holding register.
module spi_slave #(
  parameter int unsigned          DATA_WIDTH  = 8,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_FILL  = {DATA_WIDTH{1'b1}}
) (
  input logic        clk,
  input logic        rst,
  spi_slave_if.slave bus
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  // Synchronisers and edge detection
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES:0]   flush_q, flush_d;
  logic                   cs_dly_q, sclk_dly_q, armed_q, armed_d;
  logic                   cs_s, sclk_s, mosi_s;
  logic                   cs_fall, cs_rise, sclk_rise, sclk_fall;

  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
    flush_d     = {flush_q[SYNC_STAGES-1:0], 1'b1};
    // A frame may only start once cs has been seen high after the chain flushed out of reset
    armed_d     = armed_q | (flush_q[SYNC_STAGES] & cs_s);
  end

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_fall   = armed_q & cs_dly_q & ~cs_s;
  assign cs_rise   = ~cs_dly_q & cs_s;
  assign sclk_rise = ~sclk_dly_q & sclk_s;
  assign sclk_fall = sclk_dly_q & ~sclk_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      flush_q     <= '0;
      cs_dly_q    <= 1'b1;
      sclk_dly_q  <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      flush_q     <= flush_d;
      cs_dly_q    <= cs_s;
      sclk_dly_q  <= sclk_s;
      armed_q     <= armed_d;
    end
  end

  // Frame state
  state_e                state_q, state_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  pend_q, pend_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  done_q, done_d;
  logic                  underrun_q, underrun_d;
  logic                  abort_q, abort_d;
  logic                  reload_q, reload_d;
  logic                  spec_q, spec_d;
  logic                  spec_fill_q, spec_fill_d;
  logic                  spec_pend_q, spec_pend_d;
  logic [DATA_WIDTH-1:0] load_byte;
  logic                  load_fill;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    pend_d      = pend_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    done_d      = 1'b0;
    underrun_d  = 1'b0;
    abort_d     = 1'b0;
    reload_d    = reload_q;
    spec_d      = spec_q;
    spec_fill_d = spec_fill_q;
    spec_pend_d = spec_pend_q;

    // A write coinciding with a load is forwarded straight into tx_shift
    load_fill = ~bus.data_send_enable & ~pend_q;
    load_byte = bus.data_send_enable ? bus.data_send_slave : (pend_q ? hold_q : IDLE_FILL);

    if (bus.data_send_enable) begin
      hold_d = bus.data_send_slave;
      pend_d = 1'b1;
    end

    if (done_q) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d    = StShift;
          bit_cnt_d  = '0;
          tx_shift_d = load_byte;
          pend_d     = 1'b0;
          underrun_d = load_fill;
          reload_d   = 1'b0;
          spec_d     = 1'b0;
        end
      end
      StShift: begin
        if (cs_rise) begin
          state_d   = StIdle;
          abort_d   = (bit_cnt_q != '0);
          bit_cnt_d = '0;
          reload_d  = 1'b0;
          spec_d    = 1'b0;
          // The last falling edge of a frame preloads a byte nobody clocks out; give it back
          if (spec_q && spec_pend_q) begin
            pend_d = 1'b1;
          end
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
          if (spec_q) begin
            spec_d     = 1'b0;
            underrun_d = spec_fill_q;
          end
          if (bit_cnt_q == CntW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            done_d    = 1'b1;
            reload_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end else if (sclk_fall) begin
          if (reload_q) begin
            tx_shift_d  = load_byte;
            pend_d      = 1'b0;
            reload_d    = 1'b0;
            spec_d      = 1'b1;
            spec_fill_d = load_fill;
            spec_pend_d = ~load_fill;
          end else begin
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      pend_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
      reload_q    <= 1'b0;
      spec_q      <= 1'b0;
      spec_fill_q <= 1'b0;
      spec_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      pend_q      <= pend_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      abort_q     <= abort_d;
      reload_q    <= reload_d;
      spec_q      <= spec_d;
      spec_fill_q <= spec_fill_d;
      spec_pend_q <= spec_pend_d;
    end
  end

  assign bus.miso                      = (state_q == StShift) & tx_shift_q[DATA_WIDTH-1];
  assign bus.busy                      = (state_q == StShift);
  assign bus.data_receive_slave        = rx_data_q;
  assign bus.data_receive_slave_enable = rx_valid_q;
  assign bus.tx_underrun               = underrun_q;
  assign bus.frame_abort               = abort_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of single frames plus hand sequences for
// back-to-back, abort, mid-frame reset and same-cycle write forwarding.
module tb_spi_slave;

  localparam int Half = 4;  // sclk half period in clk cycles (clk/sclk ratio 8)

  logic clk = 1'b0;
  logic rst;

  spi_slave_if #(.DATA_WIDTH(8)) bus ();

  spi_slave #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2),
    .IDLE_FILL  (8'hFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Pulse monitors
  int         rx_cnt = 0;
  int         ur_cnt = 0;
  int         ab_cnt = 0;
  logic [7:0] rx_last = 8'h00;
  logic [7:0] rx_prev = 8'h00;

  always @(negedge clk) begin
    if (bus.data_receive_slave_enable === 1'b1) begin
      rx_cnt  = rx_cnt + 1;
      rx_prev = rx_last;
      rx_last = bus.data_receive_slave;
    end
    if (bus.tx_underrun === 1'b1) ur_cnt = ur_cnt + 1;
    if (bus.frame_abort === 1'b1) ab_cnt = ab_cnt + 1;
  end

  typedef struct {
    bit         wr;
    logic [7:0] wdata;
    logic [7:0] mo;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    int         exp_ur;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_write(input logic [7:0] d);
    @(negedge clk);
    bus.data_send_slave  = d;
    bus.data_send_enable = 1'b1;
    @(negedge clk);
    bus.data_send_enable = 1'b0;
  endtask

  // One sclk half period, optionally pulsing a host write on its first cycle
  task automatic half(input bit wr, input logic [7:0] wd);
    for (int i = 0; i < Half; i++) begin
      @(negedge clk);
      if (wr && i == 0) begin
        bus.data_send_slave  = wd;
        bus.data_send_enable = 1'b1;
      end else begin
        bus.data_send_enable = 1'b0;
      end
    end
  endtask

  // Master-side byte: set mosi, wait low half, sample miso, rise, wait high half, fall
  task automatic xfer_byte(input logic [7:0] mo, input bit wr, input logic [7:0] wd,
                           output logic [7:0] mi);
    for (int b = 7; b >= 0; b--) begin
      bus.mosi = mo[b];
      half(wr && b == 5, wd);
      mi[b]    = bus.miso;
      bus.sclk = 1'b1;
      half(1'b0, 8'h00);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.cs = 1'b0;
  endtask

  task automatic cs_high();
    half(1'b0, 8'h00);
    bus.cs   = 1'b1;
    bus.mosi = 1'b0;
    wait_clk(8);
  endtask

  logic [7:0] m1, m2;
  int         rx0, ur0, ab0;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{wr: 1'b1, wdata: 8'h5A, mo: 8'hA3, exp_miso: 8'h5A, exp_rx: 8'hA3, exp_ur: 0};
    vecs[1] = '{wr: 1'b0, wdata: 8'h00, mo: 8'h42, exp_miso: 8'hFF, exp_rx: 8'h42, exp_ur: 1};
    vecs[2] = '{wr: 1'b1, wdata: 8'h81, mo: 8'h00, exp_miso: 8'h81, exp_rx: 8'h00, exp_ur: 0};
    vecs[3] = '{wr: 1'b1, wdata: 8'h00, mo: 8'hFF, exp_miso: 8'h00, exp_rx: 8'hFF, exp_ur: 0};

    rst                  = 1'b1;
    bus.cs               = 1'b1;
    bus.sclk             = 1'b0;
    bus.mosi             = 1'b0;
    bus.data_send_slave  = 8'h00;
    bus.data_send_enable = 1'b0;
    #23;
    check("reset_miso", 32'(bus.miso), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_rx", 32'(bus.data_receive_slave), 32'd0);
    check("reset_strobes", 32'({bus.data_receive_slave_enable, bus.tx_underrun, bus.frame_abort}),
          32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_clk(10);

    // Table of isolated frames
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].wr) host_write(vecs[i].wdata);
      wait_clk(4);
      rx0 = rx_cnt; ur0 = ur_cnt; ab0 = ab_cnt;
      cs_low();
      xfer_byte(vecs[i].mo, 1'b0, 8'h00, m1);
      cs_high();
      check($sformatf("vec%0d_miso", i), 32'(m1), 32'(vecs[i].exp_miso));
      check($sformatf("vec%0d_rx", i), 32'(rx_last), 32'(vecs[i].exp_rx));
      check($sformatf("vec%0d_rx_cnt", i), 32'(rx_cnt - rx0), 32'd1);
      check($sformatf("vec%0d_underrun", i), 32'(ur_cnt - ur0), 32'(vecs[i].exp_ur));
      check($sformatf("vec%0d_abort", i), 32'(ab_cnt - ab0), 32'd0);
      check($sformatf("vec%0d_idle_miso", i), 32'(bus.miso), 32'd0);
      check($sformatf("vec%0d_idle_busy", i), 32'(bus.busy), 32'd0);
    end

    // Back-to-back bytes with a write landing during byte 1
    host_write(8'h11);
    wait_clk(4);
    rx0 = rx_cnt; ur0 = ur_cnt;
    cs_low();
    xfer_byte(8'hC3, 1'b1, 8'h22, m1);
    xfer_byte(8'h3C, 1'b0, 8'h00, m2);
    cs_high();
    check("b2b_miso0", 32'(m1), 32'h11);
    check("b2b_miso1", 32'(m2), 32'h22);
    check("b2b_rx_cnt", 32'(rx_cnt - rx0), 32'd2);
    check("b2b_rx0", 32'(rx_prev), 32'hC3);
    check("b2b_rx1", 32'(rx_last), 32'h3C);
    check("b2b_underrun", 32'(ur_cnt - ur0), 32'd0);

    // Abort after 5 rising edges
    rx0 = rx_cnt; ab0 = ab_cnt;
    cs_low();
    for (int b = 0; b < 5; b++) begin
      bus.mosi = 1'b1;
      half(1'b0, 8'h00);
      bus.sclk = 1'b1;
      half(1'b0, 8'h00);
      bus.sclk = 1'b0;
    end
    cs_high();
    check("abort_pulse", 32'(ab_cnt - ab0), 32'd1);
    check("abort_no_rx", 32'(rx_cnt - rx0), 32'd0);
    check("abort_rx_kept", 32'(bus.data_receive_slave), 32'h3C);
    check("abort_miso", 32'(bus.miso), 32'd0);
    rx0 = rx_cnt;
    cs_low();
    xfer_byte(8'h96, 1'b0, 8'h00, m1);
    cs_high();
    check("after_abort_rx", 32'(rx_last), 32'h96);
    check("after_abort_rx_cnt", 32'(rx_cnt - rx0), 32'd1);

    // Reset after 3 bits, cs kept low through release
    rx0 = rx_cnt;
    cs_low();
    for (int b = 0; b < 3; b++) begin
      bus.mosi = 1'b0;
      half(1'b0, 8'h00);
      bus.sclk = 1'b1;
      half(1'b0, 8'h00);
      bus.sclk = 1'b0;
    end
    wait_clk(3);
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    check("pre_reset_miso", 32'(bus.miso), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_reset_miso", 32'(bus.miso), 32'd0);
    check("mid_reset_busy", 32'(bus.busy), 32'd0);
    check("mid_reset_rx", 32'(bus.data_receive_slave), 32'd0);
    wait_clk(3);
    rst = 1'b0;
    wait_clk(12);
    check("release_cs_low_busy", 32'(bus.busy), 32'd0);
    check("release_no_rx", 32'(rx_cnt - rx0), 32'd0);
    bus.cs = 1'b1;
    wait_clk(8);
    rx0 = rx_cnt;
    cs_low();
    xfer_byte(8'hE7, 1'b0, 8'h00, m1);
    cs_high();
    check("post_reset_rx", 32'(rx_last), 32'hE7);
    check("post_reset_rx_cnt", 32'(rx_cnt - rx0), 32'd1);

    // Write on the cycle the synchronised cs falls is forwarded into the frame
    ur0 = ur_cnt;
    @(negedge clk);
    bus.cs = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.data_send_slave  = 8'h77;
    bus.data_send_enable = 1'b1;
    @(negedge clk);
    bus.data_send_enable = 1'b0;
    xfer_byte(8'h5A, 1'b0, 8'h00, m1);
    cs_high();
    check("fwd_miso", 32'(m1), 32'h77);
    check("fwd_underrun", 32'(ur_cnt - ur0), 32'd0);
    // Forwarded byte must not linger as pending
    ur0 = ur_cnt;
    cs_low();
    xfer_byte(8'h01, 1'b0, 8'h00, m1);
    cs_high();
    check("fwd_not_pending_miso", 32'(m1), 32'hFF);
    check("fwd_not_pending_underrun", 32'(ur_cnt - ur0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
